// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM states and sizing helper for the HI/LO multiply/divide unit.
package muldiv_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   function automatic int CNT_W(input int width);
      return $clog2(width + 1);
   endfunction

   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_seq_core.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide, one bit per step.
// result is {product_hi, product_lo} for multiply and {remainder, quotient} for divide.
module muldiv_seq_core
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               step,
   input  logic               is_div,
   input  logic [WIDTH-1:0]   a_mag,
   input  logic [WIDTH-1:0]   b_mag,
   output logic [2*WIDTH-1:0] result
);

   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] operand_b;
   logic             div_mode;

   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             fits;

   // The borrow bit of the trial subtraction tells whether the divisor fits this step.
   always_comb begin
      add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : '0);
      shifted = {acc_hi, acc_lo[WIDTH-1]};
      trial   = shifted - {1'b0, operand_b};
      fits    = ~trial[WIDTH];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_hi    <= '0;
         acc_lo    <= '0;
         operand_b <= '0;
         div_mode  <= 1'b0;
      end else if (start) begin
         acc_hi    <= '0;
         acc_lo    <= a_mag;
         operand_b <= b_mag;
         div_mode  <= is_div;
      end else if (step) begin
         if (div_mode) begin
            if (fits) begin
               acc_hi <= trial[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
               acc_hi <= shifted[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc_hi <= add_sum[WIDTH:1];
            acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
         end
      end
   end

   assign result = {acc_hi, acc_lo};

endmodule

// File: rtl/muldiv_hilo_unit.sv
// MULT/MULTU/DIV/DIVU engine with the architectural HI/LO pair and a valid/ready issue port.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle array product.
module muldiv_hilo_unit
   import muldiv_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] HILO_RST = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   input  logic [2:0]       op_code,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             abort,
   output logic             op_ready,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int CW = CNT_W(WIDTH);

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [2:0]         op_q;
   logic [WIDTH-1:0]   rs_q;
   logic [WIDTH-1:0]   rt_q;

   logic               accept;
   logic [WIDTH-1:0]   a_mag_in;
   logic [WIDTH-1:0]   b_mag_in;
   logic [2*WIDTH-1:0] core_result;
   logic [2*WIDTH-1:0] mul_raw;

   logic               rs_neg;
   logic               rt_neg;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;
   logic               fix_dz;

   assign op_ready = (state == ST_IDLE);
   assign busy     = ~op_ready;
   assign accept   = op_valid & op_ready;

   // The datapath only ever sees magnitudes; signs are reapplied in FIX from the captured operands.
   assign a_mag_in = (is_signed_op(op_code) && rs_data[WIDTH-1]) ? -rs_data : rs_data;
   assign b_mag_in = (is_signed_op(op_code) && rt_data[WIDTH-1]) ? -rt_data : rt_data;

   muldiv_seq_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .start  (accept && (op_code <= OP_DIVU)),
      .step   (state == ST_RUN),
      .is_div (is_div_op(op_code)),
      .a_mag  (a_mag_in),
      .b_mag  (b_mag_in),
      .result (core_result)
   );

   assign rs_neg = is_signed_op(op_q) && rs_q[WIDTH-1];
   assign rt_neg = is_signed_op(op_q) && rt_q[WIDTH-1];

`ifdef MULDIV_FAST_MUL_EN
   logic [WIDTH-1:0] rs_q_mag;
   logic [WIDTH-1:0] rt_q_mag;
   assign rs_q_mag = rs_neg ? -rs_q : rs_q;
   assign rt_q_mag = rt_neg ? -rt_q : rt_q;
   assign mul_raw  = {{WIDTH{1'b0}}, rs_q_mag} * {{WIDTH{1'b0}}, rt_q_mag};
`else
   assign mul_raw  = core_result;
`endif

   // Sign correction and the divide-by-zero convention, evaluated while in FIX.
   always_comb begin
      prod   = '0;
      quo    = '0;
      rem    = '0;
      fix_hi = hi_out;
      fix_lo = lo_out;
      fix_dz = 1'b0;
      if (is_div_op(op_q)) begin
         if (rt_q == '0) begin
            fix_lo = '1;
            fix_hi = rs_q;
            fix_dz = 1'b1;
         end else begin
            quo    = core_result[WIDTH-1:0];
            rem    = core_result[2*WIDTH-1:WIDTH];
            fix_lo = (rs_neg ^ rt_neg) ? -quo : quo;
            fix_hi = rs_neg ? -rem : rem;
         end
      end else begin
         prod   = (rs_neg ^ rt_neg) ? -mul_raw : mul_raw;
         fix_hi = prod[2*WIDTH-1:WIDTH];
         fix_lo = prod[WIDTH-1:0];
      end
   end

   // Control FSM; abort from RUN or FIX drops back to IDLE without touching HI/LO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         op_q     <= '0;
         rs_q     <= '0;
         rt_q     <= '0;
         hi_out   <= HILO_RST;
         lo_out   <= HILO_RST;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  case (op_code)
                     OP_MTHI: hi_out <= rs_data;
                     OP_MTLO: lo_out <= rs_data;
                     OP_MULT, OP_MULTU: begin
                        op_q <= op_code;
                        rs_q <= rs_data;
                        rt_q <= rt_data;
                        cnt  <= '0;
`ifdef MULDIV_FAST_MUL_EN
                        state <= ST_FIX;
`else
                        state <= ST_RUN;
`endif
                     end
                     OP_DIV, OP_DIVU: begin
                        op_q  <= op_code;
                        rs_q  <= rs_data;
                        rt_q  <= rt_data;
                        cnt   <= '0;
                        state <= ST_RUN;
                     end
                     default: ;
                  endcase
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else if (cnt == CW'(WIDTH - 1)) begin
                  state <= ST_FIX;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_FIX: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else begin
                  hi_out   <= fix_hi;
                  lo_out   <= fix_lo;
                  done     <= 1'b1;
                  div_zero <= fix_dz;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: expected HI/LO/div_zero/latency are queued at issue and checked at done.
module tb_muldiv_hilo_unit;
   import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
      int          acc_cyc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        op_valid;
   logic [2:0]  op_code;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        abort;
   logic        op_ready;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   logic [31:0] last_hi;

   muldiv_hilo_unit #(
      .WIDTH    (32),
      .HILO_RST (32'h0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .op_valid (op_valid),
      .op_code  (op_code),
      .rs_data  (rs_data),
      .rt_data  (rt_data),
      .abort    (abort),
      .op_ready (op_ready),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi_out   (hi_out),
      .lo_out   (lo_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   function automatic exp_t modelOp(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
      exp_t   e;
      longint q;
      longint r;
      logic [63:0] p;
      e.hi = '0; e.lo = '0; e.dz = 1'b0; e.lat = DIV_LAT; e.acc_cyc = 0;
      case (op)
         OP_MULT: begin
            p = longint'($signed(rs)) * longint'($signed(rt));
            e.hi = p[63:32]; e.lo = p[31:0]; e.lat = MUL_LAT;
         end
         OP_MULTU: begin
            p = {32'h0, rs} * {32'h0, rt};
            e.hi = p[63:32]; e.lo = p[31:0]; e.lat = MUL_LAT;
         end
         default: begin
            if (rt == 32'h0) begin
               e.hi = rs; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
            end else if (op == OP_DIV) begin
               q = longint'($signed(rs)) / longint'($signed(rt));
               r = longint'($signed(rs)) % longint'($signed(rt));
               e.lo = q[31:0]; e.hi = r[31:0];
            end else begin
               e.lo = rs / rt; e.hi = rs % rt;
            end
         end
      endcase
      return e;
   endfunction

   // Issue one op when the unit is ready; operands are scrambled afterwards to prove capture.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt, input bit track);
      exp_t e;
      int   n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!op_ready && n < 200);
      if (!op_ready) checkOutput("ready_timeout", {63'h0, op_ready}, 64'h1);
      op_valid = 1'b1; op_code = op; rs_data = rs; rt_data = rt;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      rs_data  = $urandom;
      rt_data  = $urandom;
      if (track) begin
         e = modelOp(op, rs, rt);
         e.acc_cyc = cyc;
         sb.push_back(e);
      end
   endtask

   task automatic waitDone();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 200);
      if (!done) checkOutput("done_timeout", {63'h0, done}, 64'h1);
   endtask

   // Scoreboard side: every done pulse must match the oldest issued op.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         checkOutput("sb_depth", 64'(sb.size() > 0), 64'h1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("hi", {32'h0, hi_out}, {32'h0, e.hi});
            checkOutput("lo", {32'h0, lo_out}, {32'h0, e.lo});
            checkOutput("div_zero", {63'h0, div_zero}, {63'h0, e.dz});
            checkOutput("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got hang, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [2:0]  rop;
      logic [31:0] rrs;
      logic [31:0] rrt;
      rst = 1'b1; op_valid = 1'b0; op_code = '0; rs_data = '0; rt_data = '0; abort = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_hi", {32'h0, hi_out}, 64'h0);
      checkOutput("rst_lo", {32'h0, lo_out}, 64'h0);
      checkOutput("rst_done", {63'h0, done}, 64'h0);
      checkOutput("rst_dz", {63'h0, div_zero}, 64'h0);
      checkOutput("rst_ready", {63'h0, op_ready}, 64'h1);
      checkOutput("rst_busy", {63'h0, busy}, 64'h0);
      rst = 1'b0;

      $display("[TB] signed and unsigned multiply");
      applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
      checkOutput("mult_busy", {63'h0, busy}, {63'h0, MUL_LAT > 1});
      waitDone();
      checkOutput("mult_hi_k", {32'h0, hi_out}, 64'hFFFF_FFFF);
      checkOutput("mult_lo_k", {32'h0, lo_out}, 64'hFFFF_FFEB);
      applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      waitDone();
      checkOutput("multu_hi_k", {32'h0, hi_out}, 64'hFFFF_FFFE);
      checkOutput("multu_lo_k", {32'h0, lo_out}, 64'h1);

      $display("[TB] divide cases");
      applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
      waitDone();
      checkOutput("div_lo_k", {32'h0, lo_out}, 64'hFFFF_FFFD);
      checkOutput("div_hi_k", {32'h0, hi_out}, 64'hFFFF_FFFF);
      applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      waitDone();
      checkOutput("divovf_lo_k", {32'h0, lo_out}, 64'h8000_0000);
      checkOutput("divovf_hi_k", {32'h0, hi_out}, 64'h0);
      applyStimulus(OP_DIVU, 32'h0000_1234, 32'h0, 1'b1);
      waitDone();
      checkOutput("dz_pulse", {63'h0, div_zero}, 64'h1);
      @(negedge clk);
      checkOutput("dz_after", {63'h0, div_zero}, 64'h0);
      checkOutput("done_after", {63'h0, done}, 64'h0);

      $display("[TB] random ops");
      for (int i = 0; i < 8; i++) begin
         rop = 3'($urandom_range(0, 3));
         rrs = $urandom;
         rrt = (i == 5) ? 32'h0 : ((i % 2) ? 32'($urandom_range(1, 40)) : $urandom);
         if (i % 3 == 0) rrt = -rrt;
         applyStimulus(rop, rrs, rrt, 1'b1);
         waitDone();
      end
      applyStimulus(3'd6, 32'hDEAD_BEEF, 32'h1, 1'b0);
      @(negedge clk);
      checkOutput("inv_ready", {63'h0, op_ready}, 64'h1);

      $display("[TB] abort with MTHI held off");
      applyStimulus(OP_MTHI, 32'hA5A5_A5A5, 32'h0, 1'b0);
      applyStimulus(OP_MTLO, 32'hA5A5_A5A5, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("mthi", {32'h0, hi_out}, 64'hA5A5_A5A5);
      checkOutput("mtlo", {32'h0, lo_out}, 64'hA5A5_A5A5);
      applyStimulus(OP_DIVU, 32'd1000, 32'd3, 1'b0);
      op_valid = 1'b1; op_code = OP_MTHI; rs_data = 32'h5A5A_5A5A;
      repeat (8) @(posedge clk);
      #1;
      checkOutput("held_busy", {63'h0, op_ready}, 64'h0);
      checkOutput("held_hi", {32'h0, hi_out}, 64'hA5A5_A5A5);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      checkOutput("abort_ready", {63'h0, op_ready}, 64'h1);
      checkOutput("abort_done", {63'h0, done}, 64'h0);
      checkOutput("abort_hi", {32'h0, hi_out}, 64'hA5A5_A5A5);
      checkOutput("abort_lo", {32'h0, lo_out}, 64'hA5A5_A5A5);
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      checkOutput("mthi_late", {32'h0, hi_out}, 64'h5A5A_5A5A);
      repeat (40) @(negedge clk);
      checkOutput("abort_sb", 64'(sb.size()), 64'h0);

      $display("[TB] reset mid-op and back-to-back");
      applyStimulus(OP_MULT, 32'd12345, 32'd678, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("arst_hi", {32'h0, hi_out}, 64'h0);
      checkOutput("arst_lo", {32'h0, lo_out}, 64'h0);
      checkOutput("arst_ready", {63'h0, op_ready}, 64'h1);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(OP_MULT, 32'hFFFF_0001, 32'd3, 1'b1);
      last_hi = modelOp(OP_MULT, 32'hFFFF_0001, 32'd3).hi;
      waitDone();
      checkOutput("b2b_ready", {63'h0, op_ready}, 64'h1);
      op_valid = 1'b1; op_code = OP_MTLO; rs_data = 32'h1357_2468;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      checkOutput("b2b_lo", {32'h0, lo_out}, 64'h1357_2468);
      checkOutput("b2b_hi", {32'h0, hi_out}, {32'h0, last_hi});
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
